// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub. The master side supplies
// operands and consumes results; the slave side is the adder/subtractor.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  // Transfer happens on a rising edge where valid && ready; valid never waits on ready.
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor, LSB first, DIGIT bits per clock through a ripple chain.
// Optional macro SERIAL_ADDSUB_SAT_EN saturates sum on signed overflow.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  serial_addsub_if.slave    bus,
  output logic [1:0]        state_o
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] digit_sum;
  logic [DIGIT:0]   carry_chain;
  logic [WIDTH-1:0] res_next, sum_d;
  logic             last_digit, ovf_raw;

  always_comb begin
    digit_sum      = '0;
    carry_chain    = '0;
    carry_chain[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      digit_sum[i]       = a_q[i] ^ b_q[i] ^ carry_chain[i];
      carry_chain[i+1]   = (a_q[i] & b_q[i]) | (carry_chain[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // Each new digit enters at the top; after N digits the word is in place.
  assign res_next   = (res_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
  assign last_digit = (cnt_q == CW'(N - 1));
  assign ovf_raw    = carry_chain[DIGIT-1] ^ carry_chain[DIGIT];

`ifdef SERIAL_ADDSUB_SAT_EN
  // A raw sign of 1 on overflow means the true result was too positive.
  assign sum_d = !ovf_raw ? res_next :
                 (res_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}});
`else
  assign sum_d = res_next;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.a;
          b_q     <= bus.b ^ {WIDTH{bus.sub}};
          carry_q <= bus.sub;
          cnt_q   <= '0;
          res_q   <= '0;
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_next;
          carry_q <= carry_chain[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_digit) begin
            sum_q  <= sum_d;
            cout_q <= carry_chain[DIGIT];
            ovf_q  <= ovf_raw;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: two instances (DIGIT=1 and DIGIT=4, WIDTH=8) checked
// against an arithmetic reference model with directed and random operands.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       in_valid_s [2];
  logic [7:0] a_s        [2];
  logic [7:0] b_s        [2];
  logic       sub_s      [2];
  logic       out_ready_s[2];
  logic       in_ready_s [2];
  logic       out_valid_s[2];
  logic [7:0] sum_s      [2];
  logic       cout_s     [2];
  logic       ovf_s      [2];
  logic [1:0] st0, st1;

  serial_addsub_if #(.WIDTH(8)) if0 ();
  serial_addsub_if #(.WIDTH(8)) if1 ();

  assign if0.in_valid  = in_valid_s[0];
  assign if0.a         = a_s[0];
  assign if0.b         = b_s[0];
  assign if0.sub       = sub_s[0];
  assign if0.out_ready = out_ready_s[0];
  assign in_ready_s[0]  = if0.in_ready;
  assign out_valid_s[0] = if0.out_valid;
  assign sum_s[0]       = if0.sum;
  assign cout_s[0]      = if0.cout;
  assign ovf_s[0]       = if0.overflow;

  assign if1.in_valid  = in_valid_s[1];
  assign if1.a         = a_s[1];
  assign if1.b         = b_s[1];
  assign if1.sub       = sub_s[1];
  assign if1.out_ready = out_ready_s[1];
  assign in_ready_s[1]  = if1.in_ready;
  assign out_valid_s[1] = if1.out_valid;
  assign sum_s[1]       = if1.sum;
  assign cout_s[1]      = if1.cout;
  assign ovf_s[1]       = if1.overflow;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut_d1 (.clk(clk), .rst(rst), .bus(if0.slave), .state_o(st0));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut_d4 (.clk(clk), .rst(rst), .bus(if1.slave), .state_o(st1));

  // Scoreboard of expected results per unit, pushed on accept and popped on delivery.
  logic [9:0] exp_q[$];

  function automatic int n_of(input int u);
    return (u == 0) ? 8 : 2;
  endfunction

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                output logic [7:0] r, output logic c, output logic o);
    int sa, sb, t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      r = a + b;
      c = (int'(a) + int'(b)) > 255;
      t = sa + sb;
    end else begin
      r = a - b;
      c = (a >= b);
      t = sa - sb;
    end
    o = (t > 127) || (t < -128);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (o) r = (t > 127) ? 8'h7F : 8'h80;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int u, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input int hold, input bit keep_valid);
    logic [7:0] es;
    logic       ec, eo;
    logic [9:0] exp_v;
    int         k;
    bit         seen;
    model(a, b, s, es, ec, eo);
    k = 0;
    while (in_ready_s[u] !== 1'b1 && k < 50) begin tick(); k++; end
    total++;
    if (in_ready_s[u] !== 1'b1) begin
      bad++; $display("FAIL accept_ready u=%0d got=%b want=1", u, in_ready_s[u]);
    end
    in_valid_s[u] = 1'b1; a_s[u] = a; b_s[u] = b; sub_s[u] = s;
    exp_q.push_back({es, ec, eo});
    tick();
    if (!keep_valid) in_valid_s[u] = 1'b0;
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      a_s[u] = 8'($urandom); b_s[u] = 8'($urandom); sub_s[u] = 1'($urandom);
      tick(); k++;
      if (out_valid_s[u] === 1'b1) seen = 1;
      else if (keep_valid) begin
        total++;
        if (in_ready_s[u] !== 1'b0) begin
          bad++; $display("FAIL no_reaccept u=%0d in_ready=%b want=0", u, in_ready_s[u]);
        end
      end
    end
    total++;
    if (!seen || k != n_of(u)) begin
      bad++; $display("FAIL latency u=%0d got=%0d want=%0d", u, k, n_of(u));
    end
    exp_v = exp_q.pop_front();
    total++;
    if ({sum_s[u], cout_s[u], ovf_s[u]} !== exp_v) begin
      bad++;
      $display("FAIL result u=%0d a=%h b=%h sub=%b got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               u, a, b, s, sum_s[u], cout_s[u], ovf_s[u], exp_v[9:2], exp_v[1], exp_v[0]);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      total++;
      if (out_valid_s[u] !== 1'b1 || in_ready_s[u] !== 1'b0 ||
          {sum_s[u], cout_s[u], ovf_s[u]} !== exp_v) begin
        bad++;
        $display("FAIL hold u=%0d cyc=%0d ov=%b ir=%b sum=%h cout=%b ovf=%b want ov=1 ir=0 sum=%h cout=%b ovf=%b",
                 u, h, out_valid_s[u], in_ready_s[u], sum_s[u], cout_s[u], ovf_s[u],
                 exp_v[9:2], exp_v[1], exp_v[0]);
      end
    end
    out_ready_s[u] = 1'b1;
    tick();
    out_ready_s[u] = 1'b0;
    in_valid_s[u]  = 1'b0;
    total++;
    if (out_valid_s[u] !== 1'b0 || in_ready_s[u] !== 1'b1 || sum_s[u] !== exp_v[9:2]) begin
      bad++;
      $display("FAIL release u=%0d ov=%b ir=%b sum=%h want ov=0 ir=1 sum=%h",
               u, out_valid_s[u], in_ready_s[u], sum_s[u], exp_v[9:2]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (in_ready_s[u] !== 1'b0) begin
        bad++; $display("FAIL reset_in_ready u=%0d got=%b want=0", u, in_ready_s[u]);
      end
    end
    rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      total++;
      if ({in_ready_s[u], out_valid_s[u], sum_s[u], cout_s[u], ovf_s[u]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_state u=%0d ir=%b ov=%b sum=%h cout=%b ovf=%b want ir=1 ov=0 sum=00 cout=0 ovf=0",
                 u, in_ready_s[u], out_valid_s[u], sum_s[u], cout_s[u], ovf_s[u]);
      end
    end
  endtask

  task automatic test_directed();
    do_op(0, 8'h7F, 8'h01, 1'b0, 0, 0);
    do_op(0, 8'h05, 8'h07, 1'b1, 0, 0);
    do_op(0, 8'hFF, 8'h01, 1'b0, 0, 0);
    do_op(1, 8'h80, 8'h01, 1'b1, 0, 0);
    do_op(1, 8'h7F, 8'h01, 1'b0, 0, 0);
    do_op(1, 8'h00, 8'h00, 1'b1, 0, 0);
  endtask

  task automatic test_backpressure();
    do_op(0, 8'h3C, 8'h5A, 1'b0, 5, 0);
    do_op(1, 8'h10, 8'h90, 1'b1, 5, 0);
  endtask

  task automatic test_reset_mid_run();
    in_valid_s[0] = 1'b1; a_s[0] = 8'h12; b_s[0] = 8'h34; sub_s[0] = 1'b0;
    tick();
    in_valid_s[0] = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({in_ready_s[0], out_valid_s[0], sum_s[0], cout_s[0], ovf_s[0]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_run_reset ir=%b ov=%b sum=%h cout=%b ovf=%b want ir=1 ov=0 sum=00 cout=0 ovf=0",
               in_ready_s[0], out_valid_s[0], sum_s[0], cout_s[0], ovf_s[0]);
    end
    // The second unit was idle and holds its last result; reset clears it too.
    total++;
    if (sum_s[1] !== 8'h00 || in_ready_s[1] !== 1'b1) begin
      bad++; $display("FAIL mid_run_reset_u1 sum=%h ir=%b want sum=00 ir=1", sum_s[1], in_ready_s[1]);
    end
    tick();
    do_op(0, 8'hC8, 8'h64, 1'b1, 1, 0);
  endtask

  task automatic test_back_to_back();
    do_op(0, 8'h40, 8'h40, 1'b0, 0, 1);
    do_op(1, 8'h81, 8'h7F, 1'b1, 2, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_op(i % 2, 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom_range(0, 3), bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      in_valid_s[u] = 1'b0; a_s[u] = '0; b_s[u] = '0; sub_s[u] = 1'b0; out_ready_s[u] = 1'b0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
